clean_scheduler: RTL and testbench
==================================

// Module: clean_scheduler
// PURPOSE
//  Queues bounding boxes of detected stars and sequences the box-clean engine one box at a time.
//  For each box it drives the box coordinates stable, issues a 1-cycle goClean, and waits for doneClean.
//  Sits between the star-finding logic (box producer) and the clean engine, which blacks out pixels in video memory.
// PARAMETERS
//  XSZ        3     x coordinate width (matches clean engine xSz)
//  YSZ        3     y coordinate width (matches clean engine ySz)
//  DEPTH      4     box queue entries; power of 2, >=2
//  TIMEOUT    1024  max cycles in WAIT before abort (used only with CLEAN_TIMEOUT_EN)
// PORTS
//  clk         in   1        clock
//  resetn      in   1        synchronous active-low reset
//  push_valid  in   1        producer offers a box
//  push_ready  out  1        queue can accept; = !full (no same-cycle pop bypass)
//  push_xl/xr  in   XSZ      box left/right column, inclusive
//  push_yt/yb  in   YSZ      box top/bottom row, inclusive
//  flush       in   1        discard all queued (not in-flight) boxes
//  goClean     out  1        1-cycle start pulse to clean engine
//  xLeft,xRight out XSZ      registered box to engine; stable from LOAD until next LOAD
//  yTop,yBottom out YSZ      as above
//  doneClean   in   1        1-cycle completion pulse from engine
//  busy        out  1        1 in LOAD/START/WAIT/GAP
//  q_count     out  clog2(DEPTH)+1  queued entries
//  bad_box     out  1        1-cycle pulse: pushed box rejected (xl>xr or yt>yb)
//  all_done    out  1        1-cycle pulse: job finished and queue empty
//  timeout     out  1        1-cycle pulse: job aborted (0 without macro)
// BEHAVIOUR
//  Reset: all outputs 0, box regs 0, queue empty, state IDLE; push_ready=1 in the cycle after reset deasserts.
//  Push: accepted when push_valid&&push_ready at clk edge. Invalid box: handshake completes, not enqueued, bad_box=1 next cycle.
//  Boxes with xl==xr and/or yt==yb are valid (single column/row/pixel).
//  States:
//   IDLE  : if q_count!=0 -> LOAD. doneClean ignored.
//   LOAD  : pop head into xLeft..yBottom; -> START.
//   START : goClean=1 (exactly one cycle); -> WAIT.
//   WAIT  : on doneClean -> GAP; all_done=1 same transition if queue empty. doneClean pulses in any other state are ignored.
//   GAP   : 1 idle cycle (engine settles); -> LOAD if queue non-empty, else IDLE.
//  Latency: push in cycle 0 into empty queue with IDLE -> goClean high in cycle 3.
//  Back-to-back: doneClean in cycle N -> next goClean in cycle N+3.
//  Simultaneous push and pop: both take effect; q_count unchanged.
//  Full: push_ready=0; push_valid held by producer; no entry overwritten.
//  Empty: no pop; LOAD is entered only with q_count>=1.
//  flush: clears queue at edge (beats same-cycle push, which is dropped). Does not disturb LOAD/START/WAIT/GAP; current job finishes normally.
//  Pointers wrap modulo DEPTH; q_count in 0..DEPTH.
//  resetn low mid-job: immediate return to reset values; goClean not reissued; engine's late doneClean ignored in IDLE.
// CONFIGURATION
//  CLEAN_TIMEOUT_EN defined: WAIT counts cycles from entry; at TIMEOUT cycles without doneClean -> timeout=1 for 1 cycle, -> GAP.
//   Box is dropped; all_done rules as for normal completion. doneClean in the same cycle as expiry counts as success (no timeout).
//  Not defined: no counter logic; WAIT holds until doneClean; timeout tied 0.
// TESTING
//  1. Push (1,4,2,3) to empty idle queue -> goClean 1 cycle at cycle 3; outputs xLeft=1,xRight=4,yTop=2,yBottom=3 held; doneClean -> all_done pulse, busy drops after GAP.
//  2. Push 5 boxes with DEPTH=4, engine stalled -> 4 accepted into queue, first popped frees slot, push_ready timeline matches q_count; boxes cleaned in FIFO order.
//  3. Push (5,2,0,0) -> bad_box pulse, q_count stays 0, no goClean.
//  4. 3 queued, job in WAIT, assert flush -> q_count=0, current job's doneClean gives all_done, no further goClean.
//  5. resetn low during WAIT then doneClean arrives in IDLE -> no state change, no all_done, no goClean.
//  6. With CLEAN_TIMEOUT_EN, TIMEOUT=16, engine never responds -> timeout pulse 16 cycles after WAIT entry, next queued box started 3 cycles later; without macro, WAIT held.

Source files
------------

// File: rtl/clean_scheduler.sv
// ============================================================================
//  Module      : clean_scheduler
//  Description : Queues bounding boxes of detected stars and sequences the
//                box-clean engine one box at a time. For each box it drives
//                the coordinates stable, issues a 1-cycle goClean and waits
//                for doneClean before moving to the next queued box.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    XSZ      x coordinate width
//    YSZ      y coordinate width
//    DEPTH    box queue entries (power of 2, >= 2)
//    TIMEOUT  max WAIT cycles before abort (only with CLEAN_TIMEOUT_EN)
//  Optional feature macro
//    CLEAN_TIMEOUT_EN  when defined, a job stuck in WAIT for TIMEOUT cycles
//                      is aborted and flagged on 'timeout'. When undefined,
//                      WAIT holds until doneClean and 'timeout' is always 0.
//  Ports
//    clk, resetn            clock, synchronous active-low reset
//    push_valid/push_ready  producer handshake (ready = queue not full)
//    push_xl/xr/yt/yb       box to enqueue (inclusive bounds)
//    flush                  discard queued (not in-flight) boxes
//    goClean                1-cycle start pulse to the clean engine
//    xLeft/xRight/yTop/yBottom  registered box presented to the engine
//    doneClean              1-cycle completion pulse from the engine
//    busy                   a job is being sequenced (LOAD/START/WAIT/GAP)
//    q_count                number of queued boxes
//    bad_box                1-cycle pulse: pushed box had xl>xr or yt>yb
//    all_done               1-cycle pulse: job finished with queue empty
//    timeout                1-cycle pulse: job aborted in WAIT
// ============================================================================
`default_nettype none

module clean_scheduler #(
    parameter int XSZ     = 3,
    parameter int YSZ     = 3,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  logic [XSZ-1:0]             push_xl,
    input  logic [XSZ-1:0]             push_xr,
    input  logic [YSZ-1:0]             push_yt,
    input  logic [YSZ-1:0]             push_yb,
    input  logic                       flush,
    output logic                       goClean,
    output logic [XSZ-1:0]             xLeft,
    output logic [XSZ-1:0]             xRight,
    output logic [YSZ-1:0]             yTop,
    output logic [YSZ-1:0]             yBottom,
    input  logic                       doneClean,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     q_count,
    output logic                       bad_box,
    output logic                       all_done,
    output logic                       timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 2 * XSZ + 2 * YSZ;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t          r_state;
    logic [EW-1:0]   r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_push_ready;
    logic            r_bad_box;

    logic            w_push_acc;
    logic            w_box_ok;
    logic            w_enq;
    logic            w_pop;
    logic [CW-1:0]   w_count_nxt;
    logic [EW-1:0]   w_head;
    logic            w_expire;
    logic            w_can_load;

    // ------------------------------------------------------------------------
    // Box queue
    // ------------------------------------------------------------------------
    assign w_push_acc = push_valid && r_push_ready;
    assign w_box_ok   = (push_xl <= push_xr) && (push_yt <= push_yb);
    // flush wins over a same-cycle push: the handshake completes but the box
    // is dropped.
    assign w_enq      = w_push_acc && w_box_ok && !flush;
    assign w_pop      = (r_state == S_LOAD);
    assign w_head     = r_mem[r_rd_ptr];
    // A flush in the deciding cycle empties the queue, so LOAD must not be
    // entered then.
    assign w_can_load = (r_count != '0) && !flush;

    always_comb begin
        w_count_nxt = r_count;
        if (flush) begin
            w_count_nxt = '0;
        end else begin
            w_count_nxt = r_count + CW'(w_enq) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_push_ready <= 1'b0;
            r_bad_box    <= 1'b0;
        end else begin
            r_count      <= w_count_nxt;
            // Registered copy of !full for the count that will hold next cycle.
            r_push_ready <= (w_count_nxt != CW'(DEPTH));
            r_bad_box    <= w_push_acc && !w_box_ok;
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_enq) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
            end
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (resetn && w_enq) begin
            r_mem[r_wr_ptr] <= {push_xl, push_xr, push_yt, push_yb};
        end
    end

    // ------------------------------------------------------------------------
    // Optional WAIT watchdog
    // ------------------------------------------------------------------------
`ifdef CLEAN_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT) < 1) ? 1 : $clog2(TIMEOUT);

    logic [TW-1:0] r_wait_cnt;

    // Counter is 0 in the first WAIT cycle, so expiry falls on the
    // TIMEOUT-th cycle spent in WAIT. A doneClean in that cycle wins.
    always_ff @(posedge clk) begin
        if (!resetn || (r_state != S_WAIT)) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    assign w_expire = (r_state == S_WAIT) && !doneClean &&
                      (r_wait_cnt == TW'(TIMEOUT - 1));
`else
    // Constant false; TIMEOUT has no effect in this build.
    assign w_expire = (TIMEOUT < 0);
`endif

    // ------------------------------------------------------------------------
    // Sequencer FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            goClean  <= 1'b0;
            busy     <= 1'b0;
            all_done <= 1'b0;
            timeout  <= 1'b0;
            xLeft    <= '0;
            xRight   <= '0;
            yTop     <= '0;
            yBottom  <= '0;
        end else begin
            goClean  <= 1'b0;
            all_done <= 1'b0;
            timeout  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_can_load) begin
                        r_state <= S_LOAD;
                        busy    <= 1'b1;
                    end
                end
                S_LOAD: begin
                    {xLeft, xRight, yTop, yBottom} <= w_head;
                    goClean <= 1'b1;
                    r_state <= S_START;
                end
                S_START: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (doneClean || w_expire) begin
                        r_state  <= S_GAP;
                        all_done <= (w_count_nxt == '0);
                        timeout  <= w_expire;
                    end
                end
                S_GAP: begin
                    if (w_can_load) begin
                        r_state <= S_LOAD;
                    end else begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    assign push_ready = r_push_ready;
    assign q_count    = r_count;
    assign bad_box    = r_bad_box;

endmodule

`default_nettype wire

// File: tb/tb_clean_scheduler.sv
// ============================================================================
//  Module      : tb_clean_scheduler
//  Description : Directed self-checking bench for clean_scheduler
//                (XSZ=3, YSZ=3, DEPTH=4, TIMEOUT=16).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clean_scheduler;

    logic        clk = 1'b0;
    logic        resetn;
    logic        push_valid;
    logic        push_ready;
    logic [2:0]  push_xl, push_xr, push_yt, push_yb;
    logic        flush;
    logic        goClean;
    logic [2:0]  xLeft, xRight, yTop, yBottom;
    logic        doneClean;
    logic        busy;
    logic [2:0]  q_count;
    logic        bad_box;
    logic        all_done;
    logic        timeout;

    int n_tests = 0;
    int n_fail  = 0;

    // Box table: B0..B5 (B2 single pixel, B4 single row, B5 single column)
    logic [2:0] bx_xl [6] = '{3'd0, 3'd2, 3'd4, 3'd0, 3'd6, 3'd1};
    logic [2:0] bx_xr [6] = '{3'd1, 3'd3, 3'd4, 3'd7, 3'd7, 3'd1};
    logic [2:0] bx_yt [6] = '{3'd0, 3'd1, 3'd5, 3'd0, 3'd3, 3'd0};
    logic [2:0] bx_yb [6] = '{3'd1, 3'd2, 3'd5, 3'd7, 3'd3, 3'd6};

    clean_scheduler #(
        .XSZ     (3),
        .YSZ     (3),
        .DEPTH   (4),
        .TIMEOUT (16)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_xl    (push_xl),
        .push_xr    (push_xr),
        .push_yt    (push_yt),
        .push_yb    (push_yb),
        .flush      (flush),
        .goClean    (goClean),
        .xLeft      (xLeft),
        .xRight     (xRight),
        .yTop       (yTop),
        .yBottom    (yBottom),
        .doneClean  (doneClean),
        .busy       (busy),
        .q_count    (q_count),
        .bad_box    (bad_box),
        .all_done   (all_done),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_box(input int i);
        push_xl = bx_xl[i];
        push_xr = bx_xr[i];
        push_yt = bx_yt[i];
        push_yb = bx_yb[i];
    endtask

    function automatic logic [31:0] exp_box(input int i);
        return {20'd0, bx_xl[i], bx_xr[i], bx_yt[i], bx_yb[i]};
    endfunction

    function automatic logic [31:0] cur_box();
        return {20'd0, xLeft, xRight, yTop, yBottom};
    endfunction

    initial begin
        resetn     = 1'b0;
        push_valid = 1'b0;
        push_xl    = '0;
        push_xr    = '0;
        push_yt    = '0;
        push_yb    = '0;
        flush      = 1'b0;
        doneClean  = 1'b0;

        // ---------------- reset state ----------------
        tick(); tick();
        chk("rst_ready",    push_ready, 0);
        chk("rst_count",    q_count,    0);
        chk("rst_go",       goClean,    0);
        chk("rst_busy",     busy,       0);
        chk("rst_box",      cur_box(),  0);
        chk("rst_bad",      bad_box,    0);
        chk("rst_alldone",  all_done,   0);
        chk("rst_timeout",  timeout,    0);
        resetn = 1'b1;
        tick();
        chk("rst_rel_ready", push_ready, 1);

        // ---------------- T1: single box, latency ----------------
        push_valid = 1'b1;
        push_xl = 3'd1; push_xr = 3'd4; push_yt = 3'd2; push_yb = 3'd3;
        tick();                                   // cycle 1
        push_valid = 1'b0;
        chk("t1_count_c1", q_count, 1);
        chk("t1_go_c1",    goClean, 0);
        tick();                                   // cycle 2 (LOAD)
        chk("t1_busy_c2",  busy,    1);
        chk("t1_go_c2",    goClean, 0);
        tick();                                   // cycle 3 (START)
        chk("t1_go_c3",    goClean, 1);
        chk("t1_box_c3",   cur_box(), {20'd0, 3'd1, 3'd4, 3'd2, 3'd3});
        chk("t1_count_c3", q_count, 0);
        tick();                                   // cycle 4 (WAIT)
        chk("t1_go_c4",    goClean, 0);
        tick(); tick();
        doneClean = 1'b1;
        tick();                                   // GAP
        doneClean = 1'b0;
        chk("t1_alldone",  all_done, 1);
        chk("t1_busy_gap", busy,     1);
        tick();                                   // IDLE
        chk("t1_alldone_pulse", all_done, 0);
        chk("t1_busy_idle",     busy,     0);
        chk("t1_box_held",      cur_box(), {20'd0, 3'd1, 3'd4, 3'd2, 3'd3});

        // ---------------- T3: invalid box ----------------
        push_valid = 1'b1;
        push_xl = 3'd5; push_xr = 3'd2; push_yt = 3'd0; push_yb = 3'd0;
        tick();
        push_valid = 1'b0;
        chk("t3_bad",       bad_box, 1);
        chk("t3_count",     q_count, 0);
        tick();
        chk("t3_bad_pulse", bad_box, 0);
        tick(); tick();
        chk("t3_no_go",     goClean, 0);
        chk("t3_no_busy",   busy,    0);

        // ---------------- T2: fill, full, FIFO order ----------------
        push_valid = 1'b1;
        set_box(0); tick();                       // c1
        chk("t2_cnt_c1", q_count, 1);
        chk("t2_rdy_c1", push_ready, 1);
        set_box(1); tick();                       // c2 LOAD
        chk("t2_cnt_c2", q_count, 2);
        chk("t2_rdy_c2", push_ready, 1);
        set_box(2); tick();                       // c3 START
        chk("t2_cnt_c3", q_count, 2);
        chk("t2_go_c3",  goClean, 1);
        chk("t2_box0",   cur_box(), exp_box(0));
        set_box(3); tick();                       // c4 WAIT
        chk("t2_cnt_c4", q_count, 3);
        chk("t2_rdy_c4", push_ready, 1);
        set_box(4); tick();                       // c5 full
        chk("t2_cnt_c5", q_count, 4);
        chk("t2_rdy_c5", push_ready, 0);
        set_box(5); tick();                       // c6 B5 held off
        chk("t2_cnt_c6", q_count, 4);
        chk("t2_rdy_c6", push_ready, 0);
        doneClean = 1'b1;
        tick();                                   // c7 GAP
        doneClean = 1'b0;
        chk("t2_alldone_c7", all_done, 0);
        chk("t2_cnt_c7",     q_count,  4);
        tick();                                   // c8 LOAD
        chk("t2_go_c8",  goClean,    0);
        chk("t2_rdy_c8", push_ready, 0);
        tick();                                   // c9 START
        chk("t2_go_c9",  goClean,    1);
        chk("t2_box1",   cur_box(),  exp_box(1));
        chk("t2_cnt_c9", q_count,    3);
        chk("t2_rdy_c9", push_ready, 1);
        tick();                                   // c10 B5 accepted
        push_valid = 1'b0;
        chk("t2_cnt_c10", q_count,    4);
        chk("t2_rdy_c10", push_ready, 0);
        for (int j = 1; j <= 5; j++) begin
            doneClean = 1'b1;
            tick();                               // GAP
            doneClean = 1'b0;
            chk($sformatf("t2_alldone_j%0d", j), all_done, (j == 5) ? 1 : 0);
            tick();
            if (j < 5) begin
                tick();                           // START of next box
                chk($sformatf("t2_go_j%0d", j),  goClean,   1);
                chk($sformatf("t2_box_j%0d", j), cur_box(), exp_box(j + 1));
                chk($sformatf("t2_cnt_j%0d", j), q_count,   4 - j);
                tick();                           // WAIT
            end else begin
                chk("t2_busy_end", busy,    0);
                chk("t2_go_end",   goClean, 0);
            end
        end

        // ---------------- T4: flush during WAIT ----------------
        push_valid = 1'b1;
        set_box(0); tick();
        set_box(1); tick();
        set_box(2); tick();
        chk("t4_go", goClean, 1);
        set_box(3); tick();                       // WAIT, 3 queued
        chk("t4_cnt_pre", q_count, 3);
        set_box(4);
        flush = 1'b1;                             // same-cycle push dropped
        tick();
        flush = 1'b0;
        push_valid = 1'b0;
        chk("t4_cnt_flush", q_count,    0);
        chk("t4_rdy_flush", push_ready, 1);
        chk("t4_busy",      busy,       1);
        tick(); tick();
        chk("t4_no_go_wait", goClean, 0);
        doneClean = 1'b1;
        tick();
        doneClean = 1'b0;
        chk("t4_alldone", all_done, 1);
        tick();
        chk("t4_busy_idle", busy, 0);
        tick(); tick();
        chk("t4_no_go_after", goClean, 0);
        chk("t4_cnt_after",   q_count, 0);

        // ---------------- T5: reset mid-job ----------------
        push_valid = 1'b1;
        set_box(0); tick();
        set_box(1); tick();
        push_valid = 1'b0;
        tick(); tick();                           // WAIT
        chk("t5_cnt_pre", q_count, 1);
        resetn = 1'b0;
        tick();
        chk("t5_rst_cnt",  q_count,    0);
        chk("t5_rst_busy", busy,       0);
        chk("t5_rst_rdy",  push_ready, 0);
        chk("t5_rst_box",  cur_box(),  0);
        resetn = 1'b1;
        tick();
        chk("t5_rdy", push_ready, 1);
        doneClean = 1'b1;
        tick();
        doneClean = 1'b0;
        chk("t5_alldone", all_done, 0);
        chk("t5_busy",    busy,     0);
        tick(); tick(); tick();
        chk("t5_no_go",   goClean,  0);
        chk("t5_cnt",     q_count,  0);

        // ---------------- T6: engine never responds ----------------
        push_valid = 1'b1;
        set_box(0); tick();
        set_box(1); tick();
        push_valid = 1'b0;
        tick();                                   // START
        chk("t6_go", goClean, 1);
        tick();                                   // first WAIT cycle
`ifdef CLEAN_TIMEOUT_EN
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk($sformatf("t6_no_to_%0d", i), timeout, 0);
        end
        tick();                                   // 16 cycles after WAIT entry
        chk("t6_timeout",  timeout,  1);
        chk("t6_busy",     busy,     1);
        chk("t6_alldone",  all_done, 0);
        tick();
        chk("t6_to_pulse", timeout,  0);
        tick();
        chk("t6_go_next",  goClean,   1);
        chk("t6_box_next", cur_box(), exp_box(1));
`else
        for (int i = 1; i <= 40; i++) begin
            tick();
            chk($sformatf("t6_no_to_%0d", i),   timeout, 0);
            chk($sformatf("t6_no_go_%0d", i),   goClean, 0);
            chk($sformatf("t6_busy_%0d", i),    busy,    1);
        end
        doneClean = 1'b1;
        tick();
        doneClean = 1'b0;
        chk("t6_alldone", all_done, 0);
        tick(); tick();
        chk("t6_go_next",  goClean,   1);
        chk("t6_box_next", cur_box(), exp_box(1));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
